// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// master = controller, slave = datapath side.
interface mips_multicycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen;
    logic       irwrite;
    logic       regwrite;
    logic       memwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    modport master (
        input  op,
        input  funct,
        input  zero,
        output pcen,
        output irwrite,
        output regwrite,
        output memwrite,
        output iord,
        output memtoreg,
        output regdst,
        output alusrca,
        output alusrcb,
        output pcsrc,
        output alucontrol,
        output state
    );

    modport slave (
        output op,
        output funct,
        output zero,
        input  pcen,
        input  irwrite,
        input  regwrite,
        input  memwrite,
        input  iord,
        input  memtoreg,
        input  regdst,
        input  alusrca,
        input  alusrcb,
        input  pcsrc,
        input  alucontrol,
        input  state
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Moore main controller for the multicycle MIPS core: sequences the
// shared ALU/memory datapath and decodes the ALU operation.
module mips_multicycle_ctrl (
    input  logic                  clk,
    input  logic                  reset,
    mips_multicycle_ctrl_if.master ctrl
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t state_q;
    state_t state_d;
    state_t dstate;

    logic       is_lw;
    logic       is_sw;
    logic       is_r;
    logic       is_beq;
    logic       is_addi;
    logic       is_j;

    logic       pcwrite;
    logic       branch;
    logic       irwrite_s;
    logic       regwrite_s;
    logic       memwrite_s;
    logic       iord_s;
    logic       memtoreg_s;
    logic       regdst_s;
    logic       alusrca_s;
    logic [1:0] alusrcb_s;
    logic [1:0] pcsrc_s;
    logic [1:0] aluop;

    assign is_lw   = (ctrl.op == OP_LW);
    assign is_sw   = (ctrl.op == OP_SW);
    assign is_r    = (ctrl.op == OP_R);
    assign is_beq  = (ctrl.op == OP_BEQ);
    assign is_addi = (ctrl.op == OP_ADDI);
    assign is_j    = (ctrl.op == OP_J);

    always_ff @(posedge clk) begin
        if (!reset)
            state_q <= FETCH;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = FETCH;
        unique case (state_q)
            FETCH:    state_d = DECODE;
            DECODE: begin
                unique case (1'b1)
                    is_lw,
                    is_sw:   state_d = MEMADR;
                    is_r:    state_d = EXECUTE;
                    is_beq:  state_d = BRANCH;
                    is_addi: state_d = ADDIEXEC;
                    is_j:    state_d = JUMP;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR:   state_d = is_sw ? MEMWR : MEMRD;
            MEMRD:    state_d = MEMWB;
            EXECUTE:  state_d = ALUWB;
            ADDIEXEC: state_d = ADDIWB;
            default:  state_d = FETCH;
        endcase
    end

    // In reset the selects mirror FETCH; write enables are gated below.
    assign dstate = reset ? state_q : FETCH;

    always_comb begin
        pcwrite    = 1'b0;
        branch     = 1'b0;
        irwrite_s  = 1'b0;
        regwrite_s = 1'b0;
        memwrite_s = 1'b0;
        iord_s     = 1'b0;
        memtoreg_s = 1'b0;
        regdst_s   = 1'b0;
        alusrca_s  = 1'b0;
        alusrcb_s  = 2'b00;
        pcsrc_s    = 2'b00;
        aluop      = 2'b00;
        unique case (dstate)
            FETCH: begin
                irwrite_s = 1'b1;
                pcwrite   = 1'b1;
                alusrcb_s = 2'b01;
            end
            DECODE:   alusrcb_s = 2'b11;
            MEMADR: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
            end
            MEMRD:    iord_s = 1'b1;
            MEMWB: begin
                memtoreg_s = 1'b1;
                regwrite_s = 1'b1;
            end
            MEMWR: begin
                iord_s     = 1'b1;
                memwrite_s = 1'b1;
            end
            EXECUTE: begin
                alusrca_s = 1'b1;
                aluop     = 2'b10;
            end
            ALUWB: begin
                regdst_s   = 1'b1;
                regwrite_s = 1'b1;
            end
            BRANCH: begin
                alusrca_s = 1'b1;
                aluop     = 2'b01;
                pcsrc_s   = 2'b01;
                branch    = 1'b1;
            end
            ADDIEXEC: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
            end
            ADDIWB:   regwrite_s = 1'b1;
            JUMP: begin
                pcsrc_s = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    function automatic logic [2:0] alu_dec(
        input logic [1:0] op2,
        input logic [5:0] fn
    );
        logic [2:0] r;
        r = 3'b010;
        unique case (op2)
            2'b01: r = 3'b110;
            2'b10: begin
                unique case (fn)
                    6'b100010: r = 3'b110;
                    6'b100100: r = 3'b000;
                    6'b100101: r = 3'b001;
                    6'b101010: r = 3'b111;
                    default:   r = 3'b010;
                endcase
            end
            default: r = 3'b010;
        endcase
        return r;
    endfunction

    assign ctrl.pcen       = reset & (pcwrite | (branch & ctrl.zero));
    assign ctrl.irwrite    = reset & irwrite_s;
    assign ctrl.regwrite   = reset & regwrite_s;
    assign ctrl.memwrite   = reset & memwrite_s;
    assign ctrl.iord       = iord_s;
    assign ctrl.memtoreg   = memtoreg_s;
    assign ctrl.regdst     = regdst_s;
    assign ctrl.alusrca    = alusrca_s;
    assign ctrl.alusrcb    = alusrcb_s;
    assign ctrl.pcsrc      = pcsrc_s;
    assign ctrl.alucontrol = alu_dec(aluop, ctrl.funct);
    assign ctrl.state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks every instruction
// class through its state sequence and checks outputs per state.
module tb_mips_multicycle_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mips_multicycle_ctrl_if c ();

    mips_multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // seq holds the expected state of cycle i in seq[4*i +: 4]
    task automatic run(
        string       tag,
        logic [5:0]  o,
        logic [5:0]  f,
        logic        z,
        int          n,
        logic [23:0] seq,
        logic [2:0]  exp_alu,
        int          exp_pc,
        int          exp_rw,
        int          exp_mw
    );
        int npc;
        int nrw;
        int nmw;
        int nir;
        npc = 0;
        nrw = 0;
        nmw = 0;
        nir = 0;
        c.op    = o;
        c.funct = f;
        c.zero  = z;
        #1;
        for (int i = 0; i < n; i++) begin
            chk({tag, ".state"}, 8'(c.state), 8'(seq[4*i +: 4]));
            npc += int'(c.pcen);
            nrw += int'(c.regwrite);
            nmw += int'(c.memwrite);
            nir += int'(c.irwrite);
            case (c.state)
                4'd0: begin
                    chk({tag, ".f_srcb"}, 8'(c.alusrcb), 8'h1);
                    chk({tag, ".f_alu"}, 8'(c.alucontrol), 8'h2);
                    chk({tag, ".f_iord"}, 8'(c.iord), 8'h0);
                end
                4'd1: chk({tag, ".d_srcb"}, 8'(c.alusrcb), 8'h3);
                4'd2: begin
                    chk({tag, ".ma_srca"}, 8'(c.alusrca), 8'h1);
                    chk({tag, ".ma_srcb"}, 8'(c.alusrcb), 8'h2);
                end
                4'd3: chk({tag, ".mr_iord"}, 8'(c.iord), 8'h1);
                4'd4: begin
                    chk({tag, ".wb_m2r"}, 8'(c.memtoreg), 8'h1);
                    chk({tag, ".wb_rw"}, 8'(c.regwrite), 8'h1);
                end
                4'd5: begin
                    chk({tag, ".mw_iord"}, 8'(c.iord), 8'h1);
                    chk({tag, ".mw_we"}, 8'(c.memwrite), 8'h1);
                end
                4'd6: begin
                    chk({tag, ".ex_alu"}, 8'(c.alucontrol), 8'(exp_alu));
                    chk({tag, ".ex_srca"}, 8'(c.alusrca), 8'h1);
                end
                4'd7: begin
                    chk({tag, ".awb_dst"}, 8'(c.regdst), 8'h1);
                    chk({tag, ".awb_rw"}, 8'(c.regwrite), 8'h1);
                    chk({tag, ".awb_m2r"}, 8'(c.memtoreg), 8'h0);
                end
                4'd8: begin
                    chk({tag, ".br_pcen"}, 8'(c.pcen), 8'(z));
                    chk({tag, ".br_pcsrc"}, 8'(c.pcsrc), 8'h1);
                    chk({tag, ".br_alu"}, 8'(c.alucontrol), 8'h6);
                end
                4'd9: chk({tag, ".ai_srcb"}, 8'(c.alusrcb), 8'h2);
                4'd10: begin
                    chk({tag, ".aw_rw"}, 8'(c.regwrite), 8'h1);
                    chk({tag, ".aw_dst"}, 8'(c.regdst), 8'h0);
                end
                4'd11: begin
                    chk({tag, ".j_pcen"}, 8'(c.pcen), 8'h1);
                    chk({tag, ".j_pcsrc"}, 8'(c.pcsrc), 8'h2);
                end
                default: ;
            endcase
            tick();
        end
        chk({tag, ".end"}, 8'(c.state), 8'h0);
        chk({tag, ".n_pcen"}, 8'(npc), 8'(exp_pc));
        chk({tag, ".n_rw"}, 8'(nrw), 8'(exp_rw));
        chk({tag, ".n_mw"}, 8'(nmw), 8'(exp_mw));
        chk({tag, ".n_ir"}, 8'(nir), 8'h1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        c.op     = 6'b100011;
        c.funct  = 6'b000000;
        c.zero   = 1'b0;

        repeat (2) begin
            tick();
            chk("rst.state", 8'(c.state), 8'h0);
            chk("rst.pcen", 8'(c.pcen), 8'h0);
            chk("rst.irwrite", 8'(c.irwrite), 8'h0);
            chk("rst.regwrite", 8'(c.regwrite), 8'h0);
            chk("rst.memwrite", 8'(c.memwrite), 8'h0);
            chk("rst.alusrcb", 8'(c.alusrcb), 8'h1);
            chk("rst.alu", 8'(c.alucontrol), 8'h2);
        end
        reset = 1'b1;

        run("lw", 6'b100011, 6'h00, 1'b0, 5, 24'h043210, 3'b010, 1, 1, 0);
        run("sw", 6'b101011, 6'h00, 1'b0, 4, 24'h005210, 3'b010, 1, 0, 1);
        run("add", 6'b000000, 6'b100000, 1'b0, 4, 24'h007610, 3'b010, 1, 1, 0);
        run("sub", 6'b000000, 6'b100010, 1'b0, 4, 24'h007610, 3'b110, 1, 1, 0);
        run("and", 6'b000000, 6'b100100, 1'b0, 4, 24'h007610, 3'b000, 1, 1, 0);
        run("or", 6'b000000, 6'b100101, 1'b0, 4, 24'h007610, 3'b001, 1, 1, 0);
        run("slt", 6'b000000, 6'b101010, 1'b0, 4, 24'h007610, 3'b111, 1, 1, 0);
        run("rbad", 6'b000000, 6'b111111, 1'b0, 4, 24'h007610, 3'b010, 1, 1, 0);
        run("beq1", 6'b000100, 6'h00, 1'b1, 3, 24'h000810, 3'b010, 2, 0, 0);
        run("beq0", 6'b000100, 6'h00, 1'b0, 3, 24'h000810, 3'b010, 1, 0, 0);
        run("j", 6'b000010, 6'h00, 1'b0, 3, 24'h000B10, 3'b010, 2, 0, 0);
        run("addi", 6'b001000, 6'h00, 1'b0, 4, 24'h00A910, 3'b010, 1, 1, 0);
        run("ill", 6'b111111, 6'h00, 1'b0, 2, 24'h000010, 3'b010, 1, 0, 0);

        c.op = 6'b101011;
        #1;
        tick();
        chk("abort.s1", 8'(c.state), 8'h1);
        tick();
        chk("abort.s2", 8'(c.state), 8'h2);
        reset = 1'b0;
        #1;
        chk("abort.memwrite", 8'(c.memwrite), 8'h0);
        chk("abort.pcen", 8'(c.pcen), 8'h0);
        chk("abort.srca", 8'(c.alusrca), 8'h0);
        chk("abort.srcb", 8'(c.alusrcb), 8'h1);
        tick();
        chk("abort.fetch", 8'(c.state), 8'h0);
        chk("abort.mw2", 8'(c.memwrite), 8'h0);
        chk("abort.ir2", 8'(c.irwrite), 8'h0);
        reset = 1'b1;

        run("j2", 6'b000010, 6'h00, 1'b0, 3, 24'h000B10, 3'b010, 2, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
